// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box and byte-level GF(2^8) helpers for the encrypt core.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } aes_state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Byte n of the block sits at [127-8n -: 8]; row = n % 4, column = n / 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round plus the matching on-the-fly key expansion step; purely combinational.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state,
    input  logic [AES_BLOCK_W-1:0] rk,
    input  logic [7:0]             rcon,
    input  logic                   finalRound,
    output logic [AES_BLOCK_W-1:0] nextState,
    output logic [AES_BLOCK_W-1:0] nextRk
);

    logic [31:0]            w0, w1, w2, w3, temp;
    logic [AES_BLOCK_W-1:0] shifted;

    always_comb begin
        w0   = rk[127:96] ^ temp;
        w1   = rk[95:64] ^ w0;
        w2   = rk[63:32] ^ w1;
        w3   = rk[31:0] ^ w2;
        nextRk = {w0, w1, w2, w3};
    end

    assign temp    = sub_word(rot_word(rk[31:0])) ^ {rcon, 24'h000000};
    assign shifted = shift_rows(sub_bytes(state));
    assign nextState = (finalRound ? shifted : mix_columns(shifted)) ^ nextRk;

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encrypt core, one round per clock with on-the-fly key expansion.
// Optional lastKey output (final round key) enabled by defining AES_DECRYPT_KEY_OUT_EN.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a finished block
// ROUND | running rounds 1..NUM_ROUNDS, busy high
module aes128_encrypt_core
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   start,
    input  logic [AES_BLOCK_W-1:0] inputKey,
    input  logic [AES_BLOCK_W-1:0] inputData,
    output logic                   busy,
    output logic                   done,
    output logic [AES_BLOCK_W-1:0] outputData
`ifdef AES_DECRYPT_KEY_OUT_EN
    ,
    output logic [AES_BLOCK_W-1:0] lastKey
`endif
);

    localparam int ROUND_W = $clog2(NUM_ROUNDS + 1);

    aes_state_e             fsm;
    logic [ROUND_W-1:0]     roundCnt;
    logic [AES_BLOCK_W-1:0] stateReg, rkReg, nextState, nextRk;
    logic [7:0]             rcon;
    logic                   finalRound;

    assign finalRound = (roundCnt == ROUND_W'(NUM_ROUNDS));

    aes_round_comb uRound (
        .state      (stateReg),
        .rk         (rkReg),
        .rcon       (rcon),
        .finalRound (finalRound),
        .nextState  (nextState),
        .nextRk     (nextRk)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fsm        <= IDLE;
            roundCnt   <= '0;
            stateReg   <= '0;
            rkReg      <= '0;
            rcon       <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            outputData <= '0;
`ifdef AES_DECRYPT_KEY_OUT_EN
            lastKey    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        stateReg <= inputData ^ inputKey;
                        rkReg    <= inputKey;
                        rcon     <= 8'h01;
                        roundCnt <= ROUND_W'(1);
                        busy     <= 1'b1;
                        fsm      <= ROUND;
                    end
                end
                ROUND: begin
                    stateReg <= nextState;
                    rkReg    <= nextRk;
                    rcon     <= xtime(rcon);
                    if (finalRound) begin
                        outputData <= nextState;
`ifdef AES_DECRYPT_KEY_OUT_EN
                        lastKey    <= nextRk;
`endif
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        roundCnt   <= '0;
                        fsm        <= IDLE;
                    end else begin
                        roundCnt <= roundCnt + ROUND_W'(1);
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed bench for aes128_encrypt_core: FIPS-197 vectors, held start, mid-op reset.
module tb_aes128_encrypt_core;

    logic         clk, rstN, start, busy, done;
    logic [127:0] inputKey, inputData, outputData;
`ifdef AES_DECRYPT_KEY_OUT_EN
    logic [127:0] lastKey;
`endif

    aes128_encrypt_core #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .start      (start),
        .inputKey   (inputKey),
        .inputData  (inputData),
        .busy       (busy),
        .done       (done),
        .outputData (outputData)
`ifdef AES_DECRYPT_KEY_OUT_EN
        ,
        .lastKey    (lastKey)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs[3];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALL_F  = {128{1'b1}};

    // Reference model: algorithmic S-box and a full up-front key schedule.
    logic [7:0] sboxM [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sboxM[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aesRef(input logic [127:0] k, input logic [127:0] p,
                                            output logic [127:0] finalKey);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sboxM[tmp[31:24]], sboxM[tmp[23:16]], sboxM[tmp[15:8]], sboxM[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int j = 0; j < 16; j++) t[j] = sboxM[s[j]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
        end
        r = '0;
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = s[j];
        finalKey = {w[40], w[41], w[42], w[43]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one block and wait (bounded) for done; called with clk low.
    task automatic runOp(input logic [127:0] k, input logic [127:0] p,
                         output int lat, output int busyLow, output logic [127:0] ct);
        inputKey = k; inputData = p; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0; busyLow = 0;
        while (!done && lat < 30) begin
            if (!busy) busyLow++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ct = outputData;
    endtask

    int           lat, busyLow, doneSeen, gap;
    logic [127:0] ct, allFct, allFkey, dummyKey;

    initial begin
        vecs[0] = '{"c1",   C1_KEY, C1_PT, C1_CT};
        vecs[1] = '{"fipsB", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{"zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        buildSbox();
        allFct = aesRef(ALL_F, ALL_F, allFkey);

        rstN = 1'b0; start = 1'b0; inputKey = '0; inputData = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {127'b0, busy}, 128'h0);
        chk("rst_done", {127'b0, done}, 128'h0);
        chk("rst_out", outputData, 128'h0);
`ifdef AES_DECRYPT_KEY_OUT_EN
        chk("rst_lastkey", lastKey, 128'h0);
`endif
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            runOp(vecs[v].key, vecs[v].pt, lat, busyLow, ct);
            chk({vecs[v].name, "_latency"}, 128'(lat), 128'd10);
            chk({vecs[v].name, "_busy_gaps"}, 128'(busyLow), 128'd0);
            chk({vecs[v].name, "_ct"}, ct, vecs[v].ct);
            chk({vecs[v].name, "_busy_at_done"}, {127'b0, busy}, 128'h0);
`ifdef AES_DECRYPT_KEY_OUT_EN
            if (v == 1) chk("fipsB_lastkey", lastKey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
            @(negedge clk);
            chk({vecs[v].name, "_done_width"}, {127'b0, done}, 128'h0);
            inputKey = ALL_F; inputData = ALL_F;
            repeat (3) @(negedge clk);
            chk({vecs[v].name, "_ct_held"}, outputData, vecs[v].ct);
        end

        // Start held high, inputs changed mid-operation.
        inputKey = C1_KEY; inputData = C1_PT; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inputKey = ALL_F; inputData = ALL_F;
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("hold_latency", 128'(lat), 128'd10);
        chk("hold_ct_first", outputData, C1_CT);
        gap = 0;
        @(posedge clk);
        gap++;
        @(negedge clk);
        start = 1'b0;
        chk("hold_restart_busy", {127'b0, busy}, 128'h1);
        while (!done && gap < 30) begin
            @(posedge clk);
            gap++;
            @(negedge clk);
        end
        chk("hold_gap", 128'(gap), 128'd11);
        chk("hold_ct_allf", outputData, allFct);
`ifdef AES_DECRYPT_KEY_OUT_EN
        chk("hold_lastkey_allf", lastKey, allFkey);
`endif
        @(negedge clk);

        // Asynchronous reset in round 5.
        inputKey = C1_KEY; inputData = C1_PT; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        chk("midrst_busy", {127'b0, busy}, 128'h0);
        chk("midrst_done", {127'b0, done}, 128'h0);
        chk("midrst_out", outputData, 128'h0);
        @(negedge clk);
        rstN = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        chk("midrst_no_done", 128'(doneSeen), 128'd0);
        runOp(C1_KEY, C1_PT, lat, busyLow, ct);
        chk("midrst_fresh_latency", 128'(lat), 128'd10);
        chk("midrst_fresh_ct", ct, C1_CT);
        dummyKey = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
